fifo_sync_param: RTL and testbench

//   Single-clock, parametrised FIFO; successor to the depth-8 dual-clock FIFO for same-domain buffering.

---
 rtl/fifo_sync_param.sv | 135 +++++++++++++
 tb/tb_fifo_sync_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock parametrised FIFO with fill count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags.
// Build option: define FIFO_SYNC_FWFT_EN for first-word-fall-through reads.
// Without it, reads are registered with one cycle of latency and r_valid pulses.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  // almost_full as seen with zero words stored (reset / flush value)
  localparam logic              LP_AF_AT_ZERO = (AF_LEVEL == 0);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so that their difference is the fill count.
  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic                r_full;
  logic                r_empty;
  logic                r_af;
  logic                r_ae;
  logic                r_ovf;
  logic                r_udf;

  logic                w_rd_acc;
  logic                w_wr_acc;
  logic [ADDR_WIDTH:0] w_wptr_next;
  logic [ADDR_WIDTH:0] w_rptr_next;
  logic [ADDR_WIDTH:0] w_count_next;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_acc     = r_en & ~r_empty;
  assign w_wr_acc     = w_en & (~r_full | w_rd_acc);
  assign w_wptr_next  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
  assign w_rptr_next  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  assign w_count_next = w_wptr_next - w_rptr_next;

  assign count        = r_wptr - r_rptr;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  // Pointer advance, registered status flags from the next count, sticky errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= LP_AF_AT_ZERO;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= LP_AF_AT_ZERO;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_next;
      r_rptr  <= w_rptr_next;
      r_full  <= (w_count_next == LP_DEPTH);
      r_empty <= (w_count_next == '0);
      r_af    <= (w_count_next >= LP_AF);
      r_ae    <= (w_count_next <= LP_AE);
      r_ovf   <= r_ovf | (w_en & ~w_wr_acc);
      r_udf   <= r_udf | (r_en & ~w_rd_acc);
    end
  end

  // Storage write port; contents are never reset, a flush only moves pointers.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !clr) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is presented whenever the FIFO holds data; zero when empty.
  assign r_valid = ~r_empty;
  assign r_data  = r_empty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  assign r_data  = r_rdata;
  assign r_valid = r_rvalid;

  // Registered read: data lands one cycle after the accepted read and then holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (clr) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed vector table plus hand-written sequences for
// reset, wrap-around and (when FIFO_SYNC_FWFT_EN is defined) fall-through reads.
module tb_fifo_sync_param;

  logic       clk;
  logic       rstn;
  logic       clr;
  logic       w_en;
  logic [7:0] w_data;
  logic       r_en;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_vectors;
  int n_miscompares;

  fifo_sync_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (clr),
    .w_en        (w_en),
    .w_data      (w_data),
    .r_en        (r_en),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic       rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic we, input logic [7:0] wd, input logic re,
                              input int cnt, input logic fu, input logic em, input logic af,
                              input logic ae, input logic ovf, input logic udf, input logic rv,
                              input logic [7:0] rd);
    vec_t v;
    v.clr = c;  v.we = we;  v.wd = wd;  v.re = re;
    v.cnt = 4'(cnt);  v.full = fu;  v.empty = em;  v.af = af;  v.ae = ae;
    v.ovf = ovf;  v.udf = udf;  v.rv = rv;  v.rd = rd;
    return v;
  endfunction

  task automatic report(input string tag, input string field, input logic [31:0] got,
                        input logic [31:0] exp);
    n_miscompares++;
    $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, field, got, exp);
  endtask

  task automatic check_state(input string tag, input int e_cnt, input logic e_full,
                             input logic e_empty, input logic e_af, input logic e_ae,
                             input logic e_ovf, input logic e_udf);
    if (count !== 4'(e_cnt))     report(tag, "count", 32'(count), 32'(e_cnt));
    if (full !== e_full)         report(tag, "full", 32'(full), 32'(e_full));
    if (empty !== e_empty)       report(tag, "empty", 32'(empty), 32'(e_empty));
    if (almost_full !== e_af)    report(tag, "almost_full", 32'(almost_full), 32'(e_af));
    if (almost_empty !== e_ae)   report(tag, "almost_empty", 32'(almost_empty), 32'(e_ae));
    if (overflow !== e_ovf)      report(tag, "overflow", 32'(overflow), 32'(e_ovf));
    if (underflow !== e_udf)     report(tag, "underflow", 32'(underflow), 32'(e_udf));
  endtask

  task automatic check_read(input string tag, input logic e_rv, input logic [7:0] e_rd);
    if (r_valid !== e_rv)        report(tag, "r_valid", 32'(r_valid), 32'(e_rv));
    if (r_data !== e_rd)         report(tag, "r_data", 32'(r_data), 32'(e_rd));
  endtask

  // Drive one cycle of inputs, let the edge happen, settle 1 time unit after it.
  task automatic apply(input logic c, input logic we, input logic [7:0] wd, input logic re);
    clr = c;  w_en = we;  w_data = wd;  r_en = re;
    @(posedge clk);
    #1;
    clr = 1'b0;  w_en = 1'b0;  r_en = 1'b0;
    n_vectors++;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] d;
    int c;

    n_vectors = 0;
    n_miscompares = 0;
    rstn = 1'b0;  clr = 1'b0;  w_en = 1'b0;  w_data = 8'h00;  r_en = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n_vectors++;
    check_state("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_read("reset", 1'b0, 8'h00);

    // Table: fill, full read+write, overflow, drain, underflow, empty read+write, flush.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, 8'(8'hA0 + k - 1), 0, k, k == 8, 0, k >= 6, k <= 2, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h55, 1, 8, 1, 0, 1, 0, 0, 0, 1, 8'hA0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 8, 1, 0, 1, 0, 1, 0, 0, 8'hA0));
    for (int j = 1; j <= 8; j++) begin
      c = 8 - j;
      vecs.push_back(mk(0, 0, 8'h00, 1, c, 0, c == 0, c >= 6, c <= 2, 1, 0, 1,
                        (j < 8) ? 8'(8'hA0 + j) : 8'h55));
    end
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 0, 8'h55));
    vecs.push_back(mk(0, 1, 8'h11, 1, 1, 0, 0, 0, 1, 1, 1, 0, 8'h55));
    vecs.push_back(mk(1, 1, 8'h22, 1, 0, 0, 1, 0, 1, 0, 0, 0, 8'h55));
    vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h55));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 0, 1, 8'h33));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i].clr, vecs[i].we, vecs[i].wd, vecs[i].re);
      check_state(tag, int'(vecs[i].cnt), vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae,
                  vecs[i].ovf, vecs[i].udf);
`ifndef FIFO_SYNC_FWFT_EN
      check_read(tag, vecs[i].rv, vecs[i].rd);
`endif
    end

    // Asynchronous reset in the middle of traffic with a sticky flag set.
    apply(0, 0, 8'h00, 1);
    apply(0, 1, 8'h90, 0);
    apply(0, 1, 8'h91, 1);
    apply(0, 1, 8'h92, 0);
    check_state("pre_rst", 2, 0, 0, 0, 1, 0, 1);
    #3 rstn = 1'b0;
    #1;
    n_vectors++;
    check_state("mid_rst", 0, 0, 1, 0, 1, 0, 0);
    check_read("mid_rst", 1'b0, 8'h00);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    apply(0, 1, 8'h77, 0);
    check_state("post_rst_wr", 1, 0, 0, 0, 1, 0, 0);
`ifdef FIFO_SYNC_FWFT_EN
    check_read("post_rst_wr", 1'b1, 8'h77);
`endif
    apply(0, 0, 8'h00, 1);
    check_state("post_rst_rd", 0, 0, 1, 0, 1, 0, 0);
`ifndef FIFO_SYNC_FWFT_EN
    check_read("post_rst_rd", 1'b1, 8'h77);
`else
    check_read("post_rst_rd", 1'b0, 8'h00);
`endif

    // Wrap-around: 4 bursts of 5 writes then 5 reads, 20 words in total.
    d = 8'h40;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        apply(0, 1, d, 0);
        q.push_back(d);
`ifdef FIFO_SYNC_FWFT_EN
        check_read($sformatf("wrap_b%0d_w%0d", b, k), 1'b1, q[0]);
`endif
        d = d + 8'd3;
      end
      for (int k = 0; k < 5; k++) begin
`ifdef FIFO_SYNC_FWFT_EN
        check_read($sformatf("wrap_b%0d_head%0d", b, k), 1'b1, q[0]);
`endif
        apply(0, 0, 8'h00, 1);
        exp_d = q.pop_front();
`ifndef FIFO_SYNC_FWFT_EN
        check_read($sformatf("wrap_b%0d_r%0d", b, k), 1'b1, exp_d);
`endif
      end
    end
    check_state("wrap_end", 0, 0, 1, 0, 1, 0, 0);
`ifdef FIFO_SYNC_FWFT_EN
    check_read("wrap_end", 1'b0, 8'h00);
`else
    check_read("wrap_end", 1'b1, exp_d);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
